// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// Entry 0 is EX, entry 1 is MEM, and the last entry is WB.
package hazard_scoreboard_pkg;

  localparam int REG_AW      = 5;
  localparam int FWD_REGFILE = 0;
  localparam int STG_EX      = 0;
  localparam int STG_MEM     = 1;

  typedef struct packed {
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic              load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // WB sits at the end of the tracked window, whatever its depth.
  function automatic int stg_wb(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request (instruction fields) and the hazard unit's response.
// The master is the ID stage. The slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int SW    = 2,
  parameter int CNT_W = 16
);
  logic          id_valid;
  logic          id_kill;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic          id_wr_en;
  logic [AW-1:0] id_rd;
  logic          id_is_load;
  logic          id_is_branch;

  logic             stall;
  logic             pc_write;
  logic             if_id_write;
  logic             bubble;
  logic [SW-1:0]    fwd_a;
  logic [SW-1:0]    fwd_b;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_kill, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_rd, id_is_load, id_is_branch,
    input  stall, pc_write, if_id_write, bubble, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_valid, id_kill, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_rd, id_is_load, id_is_branch,
    output stall, pc_write, if_id_write, bubble, fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// Per-source scoreboard lookup: hit vector, load-use flag and forward select.
// Purely combinational. It exerts no backpressure of its own.
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SW       = $clog2(DEPTH)
) (
  input  sb_entry_t        ent [DEPTH],
  input  logic [AW-1:0]    src,
  input  logic             used,
  output logic [DEPTH-2:0] hit,
  output logic             load_use,
  output logic [SW-1:0]    fwd_sel
);

  // WB is excluded: the register file writes through, so it can never hazard.
  always_comb begin
    hit      = '0;
    load_use = 1'b0;
    fwd_sel  = SW'(FWD_REGFILE);
    for (int j = 0; j < DEPTH - 1; j++) begin
      hit[j] = used && (src != '0) && ent[j].wr && (ent[j].rd == src);
      if (hit[j] && ent[j].load && (j + 1 < LOAD_LAT))
        load_use = 1'b1;
    end
    // Descending scan, so the youngest eligible producer is written last.
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (hit[k-1] && (!ent[k-1].load || k >= LOAD_LAT))
        fwd_sel = SW'(k);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decides ID stall/bubble from a shift-register scoreboard and registers the EX forwarding selects.
// stall/bubble are combinational in the same cycle. fwd/stall_count take 1 cycle. The back end never stalls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SW       = $clog2(DEPTH),
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave sb
);

  sb_entry_t        ent_q [DEPTH];
  sb_entry_t        ent_in;
  logic [DEPTH-2:0] hit_a, hit_b;
  logic             lu_a, lu_b;
  logic [SW-1:0]    sel_a, sel_b;
  logic [SW-1:0]    fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard, stall;

  sb_match #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)) u_match_a (
    .ent(ent_q), .src(sb.id_rs), .used(sb.id_uses_rs),
    .hit(hit_a), .load_use(lu_a), .fwd_sel(sel_a)
  );

  sb_match #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)) u_match_b (
    .ent(ent_q), .src(sb.id_rt), .used(sb.id_uses_rt),
    .hit(hit_b), .load_use(lu_b), .fwd_sel(sel_b)
  );

  // Branches compare in ID, so any in-flight producer short of WB must drain first.
  assign hazard = lu_a | lu_b | (sb.id_is_branch & ((|hit_a) | (|hit_b)));
  assign stall  = sb.id_valid & ~sb.id_kill & hazard;

  assign sb.stall       = stall;
  assign sb.pc_write    = ~stall;
  assign sb.if_id_write = ~stall;
  assign sb.bubble      = stall | sb.id_kill;
  assign sb.fwd_a       = fwd_a_q;
  assign sb.fwd_b       = fwd_b_q;
  assign sb.stall_count = cnt_q;

  always_comb begin
    ent_in      = SB_BUBBLE;
    ent_in.wr   = sb.id_valid & sb.id_wr_en & ~sb.id_kill & ~stall & (sb.id_rd != '0);
    ent_in.rd   = sb.id_rd;
    ent_in.load = sb.id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        ent_q[k] <= SB_BUBBLE;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      ent_q[STG_EX] <= ent_in;
      for (int k = STG_MEM; k < DEPTH; k++)
        ent_q[k] <= ent_q[k-1];
      if (stall | sb.id_kill) begin
        fwd_a_q <= SW'(FWD_REGFILE);
        fwd_b_q <= SW'(FWD_REGFILE);
      end else begin
        fwd_a_q <= sel_a;
        fwd_b_q <= sel_b;
      end
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
